// File: rtl/midi_fifo.sv
// Single-clock byte FIFO between the MIDI receivers and the bus side of the router.
// Popped bytes land in a registered output that drives a tri-state bus under oe_n.
module midi_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic              oe_n,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_n,
    output logic              empty_n
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_pointer;
    logic [ADDR_W-1:0] wr_pointer;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] data_q;
    logic              rd_ok;
    logic              wr_ok;

    // Handshake: rd and wr are one-cycle strobes, each high cycle is one request.
    // A pop is taken only when non-empty; a push is taken when not full, or when
    // a pop is taken in the same cycle. Refused strobes are dropped silently,
    // so full_n/empty_n are the only flow control the neighbours get.
    always_comb begin
        rd_ok = rd && (count != '0);
        wr_ok = wr && ((count != FULL_COUNT) || rd_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pointer <= '0;
            wr_pointer <= '0;
            count      <= '0;
            data_q     <= '0;
        end else begin
            if (rd_ok) begin
                data_q     <= mem[rd_pointer];
                rd_pointer <= rd_pointer + PTR_ONE;
            end
            if (wr_ok) begin
                wr_pointer <= wr_pointer + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + COUNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count <= count - COUNT_ONE;
            end
        end
    end

    // Storage is never cleared; on a full-FIFO read+write the pop sees the old word.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_pointer] <= data_i;
        end
    end

    assign full_n  = (count != FULL_COUNT);
    assign empty_n = (count != '0);
    assign data_o  = oe_n ? {DATA_W{1'bz}} : data_q;

endmodule

// File: tb/tb_midi_fifo.sv
// Directed bench for midi_fifo: reset, push/pop order, empty/full edges,
// simultaneous push+pop at both limits and reset in the middle of traffic.
module tb_midi_fifo;

    logic       clk;
    logic       reset;
    logic       rd;
    logic       wr;
    logic       oe_n;
    logic [7:0] data_i;
    wire  [7:0] data_o;
    logic       full_n;
    logic       empty_n;

    int checks;
    int passes;

    midi_fifo #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .oe_n(oe_n),
        .data_i(data_i), .data_o(data_o), .full_n(full_n), .empty_n(empty_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given strobes; outputs are stable when this returns.
    task automatic cycle(input logic r, input logic w, input logic [7:0] d);
        @(negedge clk);
        rd = r; wr = w; data_i = d;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (dut.rd_pointer !== 8'h00) $display("FAIL reset_rd_ptr: got %h expected 00", dut.rd_pointer); else passes++;
        checks++; if (dut.wr_pointer !== 8'h00) $display("FAIL reset_wr_ptr: got %h expected 00", dut.wr_pointer); else passes++;
        checks++; if (full_n !== 1'b1) $display("FAIL reset_full_n: got %b expected 1", full_n); else passes++;
        checks++; if (empty_n !== 1'b0) $display("FAIL reset_empty_n: got %b expected 0", empty_n); else passes++;
        checks++; if (data_o !== 8'h00) $display("FAIL reset_data_o: got %h expected 00", data_o); else passes++;
        // Toggling oe_n must not disturb the held register or the flags.
        oe_n = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        oe_n = 1'b0;
        #1;
        checks++; if (data_o !== 8'h00) $display("FAIL oe_toggle_data_o: got %h expected 00", data_o); else passes++;
        checks++; if (empty_n !== 1'b0) $display("FAIL oe_toggle_empty_n: got %b expected 0", empty_n); else passes++;
    endtask

    task automatic test_write();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 8'(i));
            checks++; if (dut.wr_pointer !== 8'(i)) $display("FAIL wr%0d_wr_ptr: got %h expected %h", i, dut.wr_pointer, 8'(i)); else passes++;
            checks++; if (dut.mem[i-1] !== 8'(i)) $display("FAIL wr%0d_mem: got %h expected %h", i, dut.mem[i-1], 8'(i)); else passes++;
            checks++; if (dut.rd_pointer !== 8'h00) $display("FAIL wr%0d_rd_ptr: got %h expected 00", i, dut.rd_pointer); else passes++;
            checks++; if (empty_n !== 1'b1) $display("FAIL wr%0d_empty_n: got %b expected 1", i, empty_n); else passes++;
            checks++; if (full_n !== 1'b1) $display("FAIL wr%0d_full_n: got %b expected 1", i, full_n); else passes++;
        end
    endtask

    task automatic test_read();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            checks++; if (data_o !== 8'(i)) $display("FAIL rd%0d_data_o: got %h expected %h", i, data_o, 8'(i)); else passes++;
            checks++; if (dut.rd_pointer !== 8'(i)) $display("FAIL rd%0d_rd_ptr: got %h expected %h", i, dut.rd_pointer, 8'(i)); else passes++;
            checks++; if (empty_n !== (i < 4)) $display("FAIL rd%0d_empty_n: got %b expected %b", i, empty_n, (i < 4)); else passes++;
            checks++; if (full_n !== 1'b1) $display("FAIL rd%0d_full_n: got %b expected 1", i, full_n); else passes++;
        end
    endtask

    task automatic test_read_empty();
        cycle(1'b1, 1'b0, 8'h00);
        checks++; if (dut.rd_pointer !== 8'h04) $display("FAIL rd_empty_rd_ptr: got %h expected 04", dut.rd_pointer); else passes++;
        checks++; if (data_o !== 8'h04) $display("FAIL rd_empty_data_o: got %h expected 04", data_o); else passes++;
        checks++; if (empty_n !== 1'b0) $display("FAIL rd_empty_empty_n: got %b expected 0", empty_n); else passes++;
    endtask

    // Word k lands at address (4+k) mod 256 with value k ^ 0x5A.
    task automatic test_fill();
        for (int k = 0; k < 256; k++) begin
            cycle(1'b0, 1'b1, 8'(k) ^ 8'h5A);
            if (k == 254) begin
                checks++; if (full_n !== 1'b1) $display("FAIL fill255_full_n: got %b expected 1", full_n); else passes++;
            end
        end
        checks++; if (full_n !== 1'b0) $display("FAIL fill_full_n: got %b expected 0", full_n); else passes++;
        checks++; if (dut.wr_pointer !== 8'h04) $display("FAIL fill_wr_ptr: got %h expected 04", dut.wr_pointer); else passes++;
        cycle(1'b0, 1'b1, 8'hAA);
        checks++; if (dut.wr_pointer !== 8'h04) $display("FAIL overflow_wr_ptr: got %h expected 04", dut.wr_pointer); else passes++;
        checks++; if (dut.mem[4] !== 8'h5A) $display("FAIL overflow_mem4: got %h expected 5a", dut.mem[4]); else passes++;
        checks++; if (full_n !== 1'b0) $display("FAIL overflow_full_n: got %b expected 0", full_n); else passes++;
    endtask

    task automatic test_simul_full();
        cycle(1'b1, 1'b1, 8'hC3);
        checks++; if (data_o !== 8'h5A) $display("FAIL simfull_data_o: got %h expected 5a", data_o); else passes++;
        checks++; if (dut.mem[4] !== 8'hC3) $display("FAIL simfull_mem4: got %h expected c3", dut.mem[4]); else passes++;
        checks++; if (dut.rd_pointer !== 8'h05) $display("FAIL simfull_rd_ptr: got %h expected 05", dut.rd_pointer); else passes++;
        checks++; if (dut.wr_pointer !== 8'h05) $display("FAIL simfull_wr_ptr: got %h expected 05", dut.wr_pointer); else passes++;
        checks++; if (full_n !== 1'b0) $display("FAIL simfull_full_n: got %b expected 0", full_n); else passes++;
    endtask

    // Pops run from address 5 round to address 4, which now holds 0xC3.
    task automatic test_drain();
        logic [7:0] exp;
        for (int j = 0; j < 256; j++) begin
            cycle(1'b1, 1'b0, 8'h00);
            exp = (j == 255) ? 8'hC3 : (8'(j + 1) ^ 8'h5A);
            checks++; if (data_o !== exp) $display("FAIL drain%0d_data_o: got %h expected %h", j, data_o, exp); else passes++;
        end
        checks++; if (empty_n !== 1'b0) $display("FAIL drain_empty_n: got %b expected 0", empty_n); else passes++;
        checks++; if (full_n !== 1'b1) $display("FAIL drain_full_n: got %b expected 1", full_n); else passes++;
    endtask

    task automatic test_simul_empty();
        cycle(1'b1, 1'b1, 8'h77);
        checks++; if (empty_n !== 1'b1) $display("FAIL simempty_empty_n: got %b expected 1", empty_n); else passes++;
        checks++; if (dut.rd_pointer !== 8'h05) $display("FAIL simempty_rd_ptr: got %h expected 05", dut.rd_pointer); else passes++;
        checks++; if (dut.wr_pointer !== 8'h06) $display("FAIL simempty_wr_ptr: got %h expected 06", dut.wr_pointer); else passes++;
        checks++; if (data_o !== 8'hC3) $display("FAIL simempty_data_o: got %h expected c3", data_o); else passes++;
        cycle(1'b1, 1'b0, 8'h00);
        checks++; if (data_o !== 8'h77) $display("FAIL simempty_pop: got %h expected 77", data_o); else passes++;
        checks++; if (empty_n !== 1'b0) $display("FAIL simempty_pop_empty_n: got %b expected 0", empty_n); else passes++;
    endtask

    task automatic test_reset_midstream();
        cycle(1'b0, 1'b1, 8'h31);
        cycle(1'b0, 1'b1, 8'h32);
        @(negedge clk);
        reset = 1'b1; rd = 1'b1; wr = 1'b1; data_i = 8'h99;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0; rd = 1'b0; wr = 1'b0;
        #1;
        checks++; if (dut.rd_pointer !== 8'h00) $display("FAIL midrst_rd_ptr: got %h expected 00", dut.rd_pointer); else passes++;
        checks++; if (dut.wr_pointer !== 8'h00) $display("FAIL midrst_wr_ptr: got %h expected 00", dut.wr_pointer); else passes++;
        checks++; if (empty_n !== 1'b0) $display("FAIL midrst_empty_n: got %b expected 0", empty_n); else passes++;
        checks++; if (full_n !== 1'b1) $display("FAIL midrst_full_n: got %b expected 1", full_n); else passes++;
        checks++; if (data_o !== 8'h00) $display("FAIL midrst_data_o: got %h expected 00", data_o); else passes++;
        checks++; if (dut.mem[7] !== 8'h32) $display("FAIL midrst_mem7: got %h expected 32", dut.mem[7]); else passes++;
    endtask

    initial begin
        checks = 0; passes = 0;
        reset = 1'b0; rd = 1'b0; wr = 1'b0; oe_n = 1'b0; data_i = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_read_empty();
        test_fill();
        test_simul_full();
        test_drain();
        test_simul_empty();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
